// File: rtl/ps2_keymatrix_pkg.sv
// Shared types, scan-code constants and the scan-code-to-matrix lookup for ps2_keymatrix.
package ps2_keymatrix_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXTBRK,
      ST_SKIP
   } dec_state_e;

   localparam logic [7:0] CODE_E0   = 8'hE0;
   localparam logic [7:0] CODE_E1   = 8'hE1;
   localparam logic [7:0] CODE_F0   = 8'hF0;
   localparam logic [7:0] CODE_AA   = 8'hAA;
   localparam logic [7:0] CODE_FA   = 8'hFA;
   localparam logic [7:0] CODE_EE   = 8'hEE;
   localparam logic [7:0] CODE_FE   = 8'hFE;
   localparam logic [7:0] CODE_OVR0 = 8'h00;
   localparam logic [7:0] CODE_OVRF = 8'hFF;
   localparam logic [7:0] CODE_CAPS = 8'h58;

   localparam logic [2:0] SKIP_LEN   = 3'd7;
   localparam logic [3:0] FRAME_LAST = 4'd10;

   typedef struct packed {
      logic       hit;
      logic [5:0] index;
   } key_map_t;

   // Index is column*8 + row of the console matrix; bit 8 of the key is the E0 prefix.
   function automatic key_map_t key_lookup(input logic [8:0] key);
      key_map_t m;
      m.hit   = 1'b1;
      m.index = 6'd0;
      case (key)
         9'h029: m.index = 6'd1;   // Space
         9'h05A: m.index = 6'd2;   // Enter
         9'h15A: m.index = 6'd2;   // keypad Enter
         9'h014: m.index = 6'd3;   // L-Ctrl
         9'h012: m.index = 6'd4;   // L-Shift
         9'h059: m.index = 6'd4;   // R-Shift
         9'h066: m.index = 6'd5;
         9'h076: m.index = 6'd6;
         9'h00D: m.index = 6'd7;
         9'h016: m.index = 6'd8;
         9'h01E: m.index = 6'd9;
         9'h026: m.index = 6'd10;
         9'h025: m.index = 6'd11;
         9'h02E: m.index = 6'd12;
         9'h036: m.index = 6'd13;
         9'h03D: m.index = 6'd14;
         9'h03E: m.index = 6'd15;
         9'h015: m.index = 6'd16;
         9'h01D: m.index = 6'd17;
         9'h024: m.index = 6'd18;
         9'h02D: m.index = 6'd19;
         9'h02C: m.index = 6'd20;
         9'h01C: m.index = 6'd21;  // 'A'
         9'h01B: m.index = 6'd22;
         9'h023: m.index = 6'd23;
         9'h02B: m.index = 6'd24;
         9'h034: m.index = 6'd25;
         9'h01A: m.index = 6'd26;
         9'h022: m.index = 6'd27;
         9'h021: m.index = 6'd28;
         9'h02A: m.index = 6'd29;
         9'h032: m.index = 6'd30;
         9'h175: m.index = 6'd40;
         9'h172: m.index = 6'd41;
         9'h16B: m.index = 6'd42;
         9'h174: m.index = 6'd43;
         default: m.hit = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: pin synchronizers, ps2_clk glitch filter, frame assembly and timeout.
// Parity is only enforced when PS2_KEYMATRIX_PARITY_CHECK_EN is defined.
module ps2_rx
   import ps2_keymatrix_pkg::*;
#(
   parameter int filter_len     = 8,
   parameter int timeout_cycles = 200000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       err_o
);

   localparam int FW = $clog2(filter_len + 1);
   localparam int TW = $clog2(timeout_cycles + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(filter_len - 1);
   localparam logic [TW-1:0] TMR_MAX  = TW'(timeout_cycles - 1);

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [8:0]    shift_q, shift_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d, err_q, err_d;
   logic          flip, fall, par_ok, frame_ok;

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      filt_d  = filt_q;
      fcnt_d  = fcnt_q;
      flip    = 1'b0;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      if (clk_s2_q == filt_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FILT_MAX) begin
         filt_d = clk_s2_q;
         fcnt_d = '0;
         flip   = 1'b1;
      end else begin
         fcnt_d = fcnt_q + FW'(1);
      end
      fall = flip & filt_q;

      // After nine shifts shift_q holds {parity, data[7:0]}.
      par_ok = ^shift_q;
`ifdef PS2_KEYMATRIX_PARITY_CHECK_EN
      frame_ok = dat_s2_q & par_ok;
`else
      frame_ok = dat_s2_q;
`endif

      tmr_d = (bit_q == 4'd0 || flip) ? '0 : tmr_q + TW'(1);

      if (fall) begin
         if (bit_q == 4'd0) begin
            if (!dat_s2_q) bit_d = 4'd1;
         end else if (bit_q != FRAME_LAST) begin
            shift_d = {dat_s2_q, shift_q[8:1]};
            bit_d   = bit_q + 4'd1;
         end else begin
            bit_d   = 4'd0;
            valid_d = frame_ok;
            err_d   = ~frame_ok;
            if (frame_ok) byte_d = shift_q[7:0];
         end
      end else if (bit_q != 4'd0 && tmr_q == TMR_MAX) begin
         bit_d = 4'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         fcnt_q   <= '0;
         bit_q    <= 4'd0;
         shift_q  <= '0;
         tmr_q    <= '0;
         byte_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         clk_s1_q <= ps2_clk_i;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data_i;
         dat_s2_q <= dat_s1_q;
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tmr_q    <= tmr_d;
         byte_q   <= byte_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign byte_o  = byte_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard to 48-key console matrix plus alpha-lock; decoder FSM and matrix state.
// Optional parity enforcement in the receiver: PS2_KEYMATRIX_PARITY_CHECK_EN.
module ps2_keymatrix
   import ps2_keymatrix_pkg::*;
#(
   parameter int filter_len     = 8,
   parameter int timeout_cycles = 200000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [0:47] key_state,
   output logic        alpha_state,
   output logic [0:7]  scan_code,
   output logic        scan_valid,
   output logic        frame_err
);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_err;

   ps2_rx #(
      .filter_len    (filter_len),
      .timeout_cycles(timeout_cycles)
   ) u_rx (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk_i (ps2_clk),
      .ps2_data_i(ps2_data),
      .byte_o    (rx_byte),
      .valid_o   (rx_valid),
      .err_o     (rx_err)
   );

   dec_state_e  state_q, state_d;
   logic [2:0]  skip_q, skip_d;
   logic [0:47] key_q, key_d;
   logic        alpha_q, alpha_d, caps_q, caps_d;
   logic        do_make, do_brk, ext, is_caps;
   key_map_t    map;

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      key_d   = key_q;
      alpha_d = alpha_q;
      caps_d  = caps_q;
      do_make = 1'b0;
      do_brk  = 1'b0;
      ext     = 1'b0;

      if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == CODE_E0) begin
                  state_d = ST_EXT;
               end else if (rx_byte == CODE_F0) begin
                  state_d = ST_BRK;
               end else if (rx_byte == CODE_E1) begin
                  state_d = ST_SKIP;
                  skip_d  = SKIP_LEN;
               end else if (rx_byte == CODE_AA || rx_byte == CODE_OVR0 || rx_byte == CODE_OVRF) begin
                  key_d = '0;
               end else if (rx_byte != CODE_FA && rx_byte != CODE_EE && rx_byte != CODE_FE) begin
                  do_make = 1'b1;
               end
            end
            ST_EXT: begin
               if (rx_byte == CODE_F0) begin
                  state_d = ST_EXTBRK;
               end else begin
                  do_make = 1'b1;
                  ext     = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               do_brk  = 1'b1;
               state_d = ST_IDLE;
            end
            ST_EXTBRK: begin
               do_brk  = 1'b1;
               ext     = 1'b1;
               state_d = ST_IDLE;
            end
            ST_SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      map     = key_lookup({ext, rx_byte});
      is_caps = !ext && rx_byte == CODE_CAPS;

      // Caps Lock toggles only on the first make; typematic repeats see caps_q already set.
      if (do_make) begin
         if (is_caps) begin
            if (!caps_q) alpha_d = ~alpha_q;
            caps_d = 1'b1;
         end else if (map.hit) begin
            key_d[map.index] = 1'b1;
         end
      end else if (do_brk) begin
         if (is_caps) begin
            caps_d = 1'b0;
         end else if (map.hit) begin
            key_d[map.index] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         skip_q  <= 3'd0;
         key_q   <= '0;
         alpha_q <= 1'b0;
         caps_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         key_q   <= key_d;
         alpha_q <= alpha_d;
         caps_q  <= caps_d;
      end
   end

   assign key_state   = key_q;
   assign alpha_state = alpha_q;
   assign scan_code   = rx_byte;
   assign scan_valid  = rx_valid;
   assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Directed bench for ps2_keymatrix: PS/2 frames driven bit by bit, hand-computed matrix expectations.
module tb_ps2_keymatrix;

   localparam int FILT = 4;
   localparam int TMO  = 1000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [0:47] key_state;
   logic        alpha_state;
   logic [0:7]  scan_code;
   logic        scan_valid;
   logic        frame_err;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int valid_cyc = 0;
   int key_cyc = 0;
   logic [0:47] key_prev = '0;
   logic [0:47] exp_key;
   int exp_err;

   ps2_keymatrix #(
      .filter_len    (FILT),
      .timeout_cycles(TMO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key_state  (key_state),
      .alpha_state(alpha_state),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Strobe counters and the cycle of each strobe / matrix change, sampled on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (scan_valid) begin
         valid_cnt = valid_cnt + 1;
         valid_cyc = cyc;
      end
      if (frame_err) err_cnt = err_cnt + 1;
      if (key_state !== key_prev) begin
         key_cyc  = cyc;
         key_prev = key_state;
      end
   end

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop,
                             input int nbits);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (10) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (20) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (10) @(negedge clk);
      end
      ps2_data = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 11);
   endtask

   initial begin
      exp_key = '0;
      exp_err = 0;
      repeat (3) @(negedge clk);
      check("rst_key", 48'(key_state), 48'd0);
      check("rst_alpha", 48'(alpha_state), 48'd0);
      check("rst_code", 48'(scan_code), 48'd0);
      check("rst_valid", 48'(scan_valid), 48'd0);
      check("rst_err", 48'(frame_err), 48'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 'A' make then break
      send(8'h1C);
      exp_key[21] = 1'b1;
      check("a_make", 48'(key_state), 48'(exp_key));
      check("a_latency", 48'(key_cyc - valid_cyc), 48'd1);
      check("a_code", 48'(scan_code), 48'h1C);
      send(8'hF0);
      send(8'h1C);
      exp_key[21] = 1'b0;
      check("a_break", 48'(key_state), 48'(exp_key));
      check("a_valid_cnt", 48'(valid_cnt), 48'd3);

      // Extended Enter make / break
      send(8'hE0);
      send(8'h5A);
      exp_key[2] = 1'b1;
      check("ext_make", 48'(key_state), 48'(exp_key));
      send(8'hE0);
      send(8'hF0);
      send(8'h5A);
      exp_key[2] = 1'b0;
      check("ext_break", 48'(key_state), 48'(exp_key));
      check("ext_valid_cnt", 48'(valid_cnt), 48'd8);

      // Caps Lock with typematic repeats
      send(8'h58);
      check("caps_on", 48'(alpha_state), 48'd1);
      send(8'h58);
      send(8'h58);
      check("caps_repeat", 48'(alpha_state), 48'd1);
      send(8'hF0);
      send(8'h58);
      check("caps_release", 48'(alpha_state), 48'd1);
      send(8'h58);
      check("caps_off", 48'(alpha_state), 48'd0);
      check("caps_no_key", 48'(key_state), 48'(exp_key));

      // Space with flipped parity
      send_frame(8'h29, 1'b1, 1'b0, 11);
`ifdef PS2_KEYMATRIX_PARITY_CHECK_EN
      exp_err = exp_err + 1;
`else
      exp_key[1] = 1'b1;
`endif
      check("par_key", 48'(key_state), 48'(exp_key));
      check("par_err_cnt", 48'(err_cnt), 48'(exp_err));
      send(8'hF0);
      send(8'h29);
      exp_key[1] = 1'b0;
      check("par_cleanup", 48'(key_state), 48'(exp_key));

      // Bad stop bit: discarded, scan_code keeps the last good byte
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      exp_err = exp_err + 1;
      check("stop_err_cnt", 48'(err_cnt), 48'(exp_err));
      check("stop_key", 48'(key_state), 48'(exp_key));
      check("stop_code", 48'(scan_code), 48'h29);

      // Partial frame dropped by timeout, then a clean L-Shift
      send_frame(8'h12, 1'b0, 1'b0, 5);
      repeat (TMO + 10) @(negedge clk);
      send(8'h12);
      exp_key[4] = 1'b1;
      check("tmo_key", 48'(key_state), 48'(exp_key));
      check("tmo_err_cnt", 48'(err_cnt), 48'(exp_err));
      check("tmo_code", 48'(scan_code), 48'h12);

      // Pause sequence is swallowed whole (contains Ctrl 0x14 which must not register)
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h29);
      exp_key[1] = 1'b1;
      check("skip_key", 48'(key_state), 48'(exp_key));
      send(8'hF0);
      send(8'h29);
      exp_key[1] = 1'b0;

      // Hold 'A' and L-Shift, engage alpha lock, then keyboard reset code
      send(8'h1C);
      exp_key[21] = 1'b1;
      check("hold_two", 48'(key_state), 48'(exp_key));
      send(8'hF0);
      send(8'h58);
      send(8'h58);
      check("caps_again", 48'(alpha_state), 48'd1);
      send(8'hAA);
      exp_key = '0;
      check("aa_clear", 48'(key_state), 48'(exp_key));
      check("aa_alpha", 48'(alpha_state), 48'd1);

      // Extended Up arrow, then reset in the middle of a frame
      send(8'hE0);
      send(8'h75);
      exp_key[40] = 1'b1;
      check("up_key", 48'(key_state), 48'(exp_key));
      send_frame(8'h29, 1'b0, 1'b0, 4);
      reset_n = 1'b0;
      #1;
      check("mid_rst_key", 48'(key_state), 48'd0);
      check("mid_rst_alpha", 48'(alpha_state), 48'd0);
      check("mid_rst_code", 48'(scan_code), 48'd0);
      check("mid_rst_valid", 48'(scan_valid), 48'd0);
      check("mid_rst_err", 48'(frame_err), 48'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      send(8'h29);
      exp_key = '0;
      exp_key[1] = 1'b1;
      check("post_rst_key", 48'(key_state), 48'(exp_key));
      check("post_rst_code", 48'(scan_code), 48'h29);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
